// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment count display.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a} for a common-anode display.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

    // Non-decimal codes cannot be produced by the counter; show them as dark.
    function automatic logic [7:0] seg_decode(input bcd_t d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_count_display_bcd_digit.sv
// One decade (0-9) of the BCD counter; chained through carry_in_i/carry_out_o.
module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       carry_in_i,
    output logic [3:0] value_o,
    output logic       carry_out_o
);
    import seg7_pkg::*;

    bcd_t value_q, value_d;
    logic step;

    assign step        = en_i & carry_in_i;
    assign carry_out_o = step & (value_q == 4'd9);
    assign value_o     = value_q;

    // Clear has priority over any pending step.
    always_comb begin
        value_d = value_q;
        if (clr_i)
            value_d = 4'd0;
        else if (step)
            value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value_q <= 4'd0;
        else
            value_q <= value_d;
    end

endmodule

// File: rtl/seg7_count_display.sv
// Synchronizes the divider's toggling enable, counts its rising edges in 4-digit BCD
// and scans the digits onto a common-anode display. Option: LEADING_ZERO_BLANK_EN.
module seg7_count_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_in_i,
    input  logic        clr_i,
    input  logic        hold_i,
    output logic [15:0] count_o,
    output logic        carry_o,
    output logic [7:0]  seg_o,
    output logic [3:0]  an_o
);
    import seg7_pkg::*;

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic s1_q, s2_q, s3_q;
    logic inc, cnt_en;
    logic carry_q;
    logic [NUM_DIGITS:0] carry;
    bcd_t digit [NUM_DIGITS];

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             blank;

    // Two flops resynchronize the enable; the third remembers its previous level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= ce_in_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign inc      = s2_q & ~s3_q;
    assign cnt_en   = inc & ~hold_i;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (clr_i),
            .en_i        (cnt_en),
            .carry_in_i  (carry[i]),
            .value_o     (digit[i]),
            .carry_out_o (carry[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            carry_q <= 1'b0;
        else
            carry_q <= carry[NUM_DIGITS] & ~clr_i;
    end

    always_comb begin
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd3:    blank = (digit[3] == 4'd0);
            2'd2:    blank = (digit[3] == 4'd0) && (digit[2] == 4'd0);
            2'd1:    blank = (digit[3] == 4'd0) && (digit[2] == 4'd0) && (digit[1] == 4'd0);
            default: blank = 1'b0;
        endcase
`endif
        if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + CNT_W'(1);
            idx_d      = idx_q;
        end
        seg_d = blank ? SEG_BLANK : seg_decode(digit[idx_q]);
        an_d  = ~(4'b0001 << idx_q);
    end

    // AN and SEG come from the same index register so they switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            seg_q      <= SEG_BLANK;
            an_q       <= AN_OFF;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign count_o = {digit[3], digit[2], digit[1], digit[0]};
    assign carry_o = carry_q;
    assign seg_o   = seg_q;
    assign an_o    = an_q;

endmodule

// File: tb/tb_seg7_count_display.sv
// Self-checking bench for seg7_count_display with a short scan period.
// Honors LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_seg7_count_display;
    import seg7_pkg::*;

    localparam int SCAN = 4;

    logic        clk = 1'b0;
    logic        rst, ceIn, clr, hold;
    logic [15:0] countOut;
    logic        carryOut;
    logic [7:0]  segOut;
    logic [3:0]  anOut;

    int checks = 0;
    int passes = 0;
    int model  = 0;
    logic [15:0] expQ[$];

    typedef struct {
        bit clrIn;
        bit holdIn;
        int expCount;
    } ctrlVec_t;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } scanVec_t;

    ctrlVec_t ctrlTab[8];
    scanVec_t scanTab[4];

    seg7_count_display #(.SCAN_DIV(SCAN)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce_in_i (ceIn),
        .clr_i   (clr),
        .hold_i  (hold),
        .count_o (countOut),
        .carry_o (carryOut),
        .seg_o   (segOut),
        .an_o    (anOut)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] toBcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    // Compares one value and tallies the outcome.
    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // One rising edge of CE_IN with the given CLR/HOLD levels; the result is queued
    // when driven and compared three edges later.
    task automatic applyStimulus(input bit c, input bit h, input int newModel,
                                 input int highCycles, input int lowCycles, input bit checkLatency);
        int prev;
        prev  = model;
        model = newModel;
        clr   = c;
        hold  = h;
        ceIn  = 1'b1;
        expQ.push_back(toBcd(model));
        tick;
        tick;
        if (checkLatency && !c)
            checkOutput("count before latency", countOut, toBcd(prev));
        tick;
        checkOutput("count after edge", countOut, expQ.pop_front());
        clr  = 1'b0;
        hold = 1'b0;
        repeat (highCycles - 3) tick;
        ceIn = 1'b0;
        repeat (lowCycles) tick;
        if (checkLatency)
            checkOutput("count no replay", countOut, toBcd(model));
    endtask

    task automatic fastEdges(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, (model + 1) % 10000, 3, 3, 1'b0);
    endtask

    task automatic syncToAn(input logic [3:0] target);
        int n;
        n = 0;
        while (anOut !== target && n < 40) begin
            tick;
            n++;
        end
        if (n >= 40)
            checkOutput("scan sync", {12'd0, anOut}, {12'd0, target});
    endtask

    // Lines up on the first cycle of the ones digit, then walks a full refresh.
    task automatic checkScan(input string tag);
        syncToAn(4'b0111);
        syncToAn(4'b1110);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < SCAN; c++) begin
                checkOutput({tag, " an"}, {12'd0, anOut}, {12'd0, scanTab[d].an});
                checkOutput({tag, " seg"}, {8'd0, segOut}, {8'd0, scanTab[d].seg});
                tick;
            end
        end
    endtask

    initial begin
        logic [7:0] leadSeg;

        ctrlTab[0] = '{clrIn: 1'b0, holdIn: 1'b0, expCount: 4};
        ctrlTab[1] = '{clrIn: 1'b0, holdIn: 1'b1, expCount: 4};
        ctrlTab[2] = '{clrIn: 1'b1, holdIn: 1'b1, expCount: 0};
        ctrlTab[3] = '{clrIn: 1'b0, holdIn: 1'b0, expCount: 1};
        ctrlTab[4] = '{clrIn: 1'b0, holdIn: 1'b1, expCount: 1};
        ctrlTab[5] = '{clrIn: 1'b1, holdIn: 1'b0, expCount: 0};
        ctrlTab[6] = '{clrIn: 1'b0, holdIn: 1'b0, expCount: 1};
        ctrlTab[7] = '{clrIn: 1'b1, holdIn: 1'b0, expCount: 0};

        rst  = 1'b1;
        ceIn = 1'b0;
        clr  = 1'b0;
        hold = 1'b0;
        tick;
        tick;
        checkOutput("reset count", countOut, 16'h0000);
        checkOutput("reset carry", {15'd0, carryOut}, 16'd0);
        checkOutput("reset seg", {8'd0, segOut}, 16'h00FF);
        checkOutput("reset an", {12'd0, anOut}, 16'h000F);

        rst = 1'b0;
        tick;
        checkOutput("first edge an", {12'd0, anOut}, 16'h000E);
        checkOutput("first edge seg", {8'd0, segOut}, {8'd0, SEG_0});

        $display("[TB] three slow CE periods");
        for (int i = 1; i <= 3; i++)
            applyStimulus(1'b0, 1'b0, i, 10, 10, 1'b1);
        checkOutput("count after three", countOut, 16'h0003);

        $display("[TB] CLR/HOLD priority vectors");
        for (int i = 0; i < 8; i++)
            applyStimulus(ctrlTab[i].clrIn, ctrlTab[i].holdIn, ctrlTab[i].expCount, 4, 6, 1'b1);

        $display("[TB] display of 0007");
`ifdef LEADING_ZERO_BLANK_EN
        leadSeg = SEG_BLANK;
`else
        leadSeg = SEG_0;
`endif
        fastEdges(7);
        scanTab[0] = '{an: 4'b1110, seg: SEG_7};
        scanTab[1] = '{an: 4'b1101, seg: leadSeg};
        scanTab[2] = '{an: 4'b1011, seg: leadSeg};
        scanTab[3] = '{an: 4'b0111, seg: leadSeg};
        checkScan("0007");

        $display("[TB] reset in the middle of a scan at 0042");
        applyStimulus(1'b1, 1'b0, 0, 3, 3, 1'b0);
        fastEdges(42);
        checkOutput("count 0042", countOut, 16'h0042);
        syncToAn(4'b1011);
        rst = 1'b1;
        #1;
        checkOutput("async reset an", {12'd0, anOut}, 16'h000F);
        checkOutput("async reset seg", {8'd0, segOut}, 16'h00FF);
        checkOutput("async reset count", countOut, 16'h0000);
        model = 0;
        tick;
        rst = 1'b0;
        tick;
        checkOutput("post reset an", {12'd0, anOut}, 16'h000E);
        checkOutput("post reset seg", {8'd0, segOut}, {8'd0, SEG_0});

        $display("[TB] display of 1250");
        fastEdges(1250);
        scanTab[0] = '{an: 4'b1110, seg: SEG_0};
        scanTab[1] = '{an: 4'b1101, seg: SEG_5};
        scanTab[2] = '{an: 4'b1011, seg: SEG_2};
        scanTab[3] = '{an: 4'b0111, seg: SEG_1};
        checkScan("1250");

        $display("[TB] run up to 9999 and wrap");
        fastEdges(9999 - 1250);
        checkOutput("count 9999", countOut, 16'h9999);
        ceIn = 1'b1;
        expQ.push_back(16'h0000);
        tick;
        tick;
        checkOutput("carry before wrap", {15'd0, carryOut}, 16'd0);
        tick;
        checkOutput("wrap count", countOut, expQ.pop_front());
        checkOutput("wrap carry", {15'd0, carryOut}, 16'd1);
        tick;
        checkOutput("carry one cycle", {15'd0, carryOut}, 16'd0);
        ceIn = 1'b0;
        repeat (4) tick;
        checkOutput("count stays 0000", countOut, 16'h0000);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg7_count_display.md
# seg7_count_display

Consumer side of the seven-segment count-enable divider: takes the divider's slow toggling enable, synchronizes it, and turns each rising edge into one increment of a 4-digit BCD counter (0000–9999). Also time-multiplexes the four digits onto a common-anode seven-segment display. Sits between the divider and the board's segment/anode pins.

## Interface
- SCAN_DIV, 50000, CLK cycles each digit stays lit; legal range 2..2^20.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CE_IN  in  1  toggling enable from divider, asynchronous to nothing but treated as unsynchronized.
- CLR  in  1  synchronous clear of the count.
- HOLD  in  1  suppresses increments while high.
- COUNT  out  16  BCD count {thousands, hundreds, tens, ones}.
- CARRY  out  1  one-cycle pulse on 9999→0000 wrap.
- SEG  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always 1.
- AN  out  4  active-low one-hot anodes; AN[0] = ones digit.

## Operation
- Input path: CE_IN passes through 2 sync flops (s1, s2) plus a history flop s3; inc = s2 & ~s3. Only rising edges of CE_IN count; falling edges ignored.
- Count update priority per cycle: CLR (COUNT←0000) > HOLD (no change, edge discarded, not queued) > inc (BCD +1).
- BCD increment: each digit 0–9; digit at 9 with carry-in goes to 0 and carries. 9999 + 1 → 0000 with CARRY=1 that cycle; CARRY=0 otherwise, including CLR.
- Scan: counter counts 0..SCAN_DIV-1; on terminal count digit index advances 0→1→2→3→0. AN and SEG registered together from the current index, so they always change on the same edge.
- Decoding (SEG): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex). Digit values A–F cannot occur; decoder outputs FF for them.
- Reset values: COUNT=0000, CARRY=0, SEG=FF, AN=1111, scan counter 0, index 0, s1..s3=0.
- RST mid-operation: all state returns to reset values immediately; an edge in flight is lost.

## Timing
- CE_IN high first sampled at edge k into s1; s2 high at k+1; COUNT shows increment after edge k+2 (latency 3 edges).
- CE_IN must stay stable ≥3 CLK cycles per level; shorter pulses may be missed.
- CLR acts on the edge it is sampled; COUNT=0000 the following cycle.
- First edge after RST release: AN=1110, SEG = pattern of ones digit. Each digit held exactly SCAN_DIV cycles; full refresh = 4·SCAN_DIV cycles.
- COUNT change is visible on SEG at the next scan register update (≤1 cycle when that digit is active).

## Configuration
- LEADING_ZERO_BLANK_EN defined: a thousands/hundreds/tens digit that is 0 with all more-significant digits 0 drives SEG=FF (AN still scans normally); ones digit never blanked (0000 shows "   0").
- Not defined: all four digits always displayed, leading zeros shown.

## Structure
- Package seg7_pkg: segment pattern constants for 0–9, SEG_BLANK (8'hFF), AN_OFF (4'hF), NUM_DIGITS (4), BCD digit typedef (4 bits).
- Sub-module bcd_digit: one decade counter (clk, rst, clr, en, carry_in → value[3:0], carry_out), instantiated 4× in a ripple chain.

## Test plan
- Reset then toggle CE_IN (hold each level 10 cycles) 3 full periods -> COUNT=0003, exactly 3 increments, each 3 edges after CE_IN rise.
- Preload to 9999 via 9999 edges (or force), one more rising edge -> COUNT=0000, CARRY high exactly one cycle.
- CE_IN rising edge arriving with CLR=1 and HOLD=1 same cycle -> COUNT=0000; HOLD alone during edge -> COUNT unchanged, edge not replayed after HOLD drops.
- SCAN_DIV=4, COUNT=1250 -> AN sequence 1110,1101,1011,0111 each 4 cycles; SEG 92,C0? no: ones=0→C0, tens=5→92, hundreds=2→A4, thousands=1→F9.
- With LEADING_ZERO_BLANK_EN, COUNT=0007 -> SEG F8 on AN=1110, FF on the other three; without macro -> C0 on the other three.
- Assert RST while SCAN at digit 2 and COUNT=0042 -> AN=1111, SEG=FF, COUNT=0000 without waiting for a CLK edge.
